nios_system_avalon_st_upsize_adapter: RTL and testbench

//  Parametrised Avalon-ST data format adapter. Packs narrow input beats (IN_SYMBOLS symbols) into wide output beats (OUT_SYMBOLS symbols).

---
 rtl/avalon_st_dfa_pkg.sv | 25 ++
 rtl/nios_system_avalon_st_upsize_adapter_if.sv | 58 +++++
 rtl/avalon_st_dfa_out_reg.sv | 46 ++++
 rtl/nios_system_avalon_st_upsize_adapter.sv | 124 ++++++++++++
 tb/tb_nios_system_avalon_st_upsize_adapter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/avalon_st_dfa_pkg.sv
// Shared helpers for the Avalon-ST data format adapters: width derivation and
// the beat-completion decode used by the accumulator slot counter.
package avalon_st_dfa_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Widths that must never collapse to zero bits, e.g. a counter when R==1.
  function automatic int max1_clog2(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  typedef enum logic [1:0] {
    BEAT_IDLE,
    BEAT_FILL,
    BEAT_DONE
  } beat_e;

endpackage

// File: rtl/nios_system_avalon_st_upsize_adapter_if.sv
// Narrow-in / wide-out Avalon-ST stream pair for the upsize adapter.
// in_empty exists only when DFA_IN_EMPTY_EN is defined.
interface nios_system_avalon_st_upsize_adapter_if #(
  parameter int SYMBOL_W    = 8,
  parameter int IN_SYMBOLS  = 1,
  parameter int OUT_SYMBOLS = 4,
  parameter int CHANNEL_W   = 2,
  parameter int ERROR_W     = 6
) ();
  import avalon_st_dfa_pkg::*;

  localparam int IN_W       = SYMBOL_W * IN_SYMBOLS;
  localparam int OUT_W      = SYMBOL_W * OUT_SYMBOLS;
  localparam int EMPTY_W    = max1_clog2(OUT_SYMBOLS);
  localparam int IN_EMPTY_W = max1_clog2(IN_SYMBOLS);

  logic                 in_ready;
  logic                 in_valid;
  logic [IN_W-1:0]      in_data;
  logic [CHANNEL_W-1:0] in_channel;
  logic [ERROR_W-1:0]   in_error;
  logic                 in_startofpacket;
  logic                 in_endofpacket;
`ifdef DFA_IN_EMPTY_EN
  logic [IN_EMPTY_W-1:0] in_empty;
`endif
  logic                 out_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic [CHANNEL_W-1:0] out_channel;
  logic [ERROR_W-1:0]   out_error;
  logic                 out_startofpacket;
  logic                 out_endofpacket;
  logic [EMPTY_W-1:0]   out_empty;

  modport slave (
    output in_ready,
    input  in_valid, in_data, in_channel, in_error, in_startofpacket, in_endofpacket,
`ifdef DFA_IN_EMPTY_EN
    input  in_empty,
`endif
    input  out_ready,
    output out_valid, out_data, out_channel, out_error, out_startofpacket,
    output out_endofpacket, out_empty
  );

  modport master (
    input  in_ready,
    output in_valid, in_data, in_channel, in_error, in_startofpacket, in_endofpacket,
`ifdef DFA_IN_EMPTY_EN
    output in_empty,
`endif
    output out_ready,
    input  out_valid, out_data, out_channel, out_error, out_startofpacket,
    input  out_endofpacket, out_empty
  );

endinterface

// File: rtl/avalon_st_dfa_out_reg.sv
// Single registered output stage with valid/ready hold; payload width is generic
// so the same stage serves both the upsize and downsize adapters.
module avalon_st_dfa_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         in_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    // load only occurs when in_ready is high, so a held beat is never overwritten
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/nios_system_avalon_st_upsize_adapter.sv
// Avalon-ST upsize adapter: packs R narrow groups into one wide beat with empty,
// channel, error and packet markers. DFA_IN_EMPTY_EN adds the in_empty port.
module nios_system_avalon_st_upsize_adapter
  import avalon_st_dfa_pkg::*;
#(
  parameter int SYMBOL_W    = 8,
  parameter int IN_SYMBOLS  = 1,
  parameter int OUT_SYMBOLS = 4,
  parameter int CHANNEL_W   = 2,
  parameter int ERROR_W     = 6
) (
  input logic clk,
  input logic reset,
  nios_system_avalon_st_upsize_adapter_if.slave st
);

  localparam int IN_W    = SYMBOL_W * IN_SYMBOLS;
  localparam int OUT_W   = SYMBOL_W * OUT_SYMBOLS;
  localparam int R       = OUT_SYMBOLS / IN_SYMBOLS;
  localparam int CNT_W   = max1_clog2(R);
  localparam int EMPTY_W = max1_clog2(OUT_SYMBOLS);
  localparam int PAY_W   = OUT_W + CHANNEL_W + ERROR_W + 2 + EMPTY_W;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]     acc_data_q, acc_data_d;
  logic [CHANNEL_W-1:0] acc_channel_q, acc_channel_d;
  logic [ERROR_W-1:0]   acc_error_q, acc_error_d;
  logic                 acc_sop_q, acc_sop_d;

  logic                 in_ready;
  logic                 accept;
  beat_e                beat;
  int                   cnt_i;
  int                   empty_i;
  logic [OUT_W-1:0]     merge_data;
  logic [CHANNEL_W-1:0] merge_channel;
  logic [ERROR_W-1:0]   merge_error;
  logic                 merge_sop;
  logic [PAY_W-1:0]     load_data;
  logic [PAY_W-1:0]     out_payload;

  assign accept = st.in_valid && in_ready;

  always_comb begin
    cnt_i = int'(cnt_q);
    if (!accept) beat = BEAT_IDLE;
    else if (cnt_q == CNT_W'(R - 1) || st.in_endofpacket) beat = BEAT_DONE;
    else beat = BEAT_FILL;

    // slots below cnt come from the accumulator, slot cnt is the live group,
    // anything above is zero so stale data from a previous packet never leaks
    merge_data = '0;
    for (int i = 0; i < R; i++) begin
      if (i < cnt_i)
        merge_data[OUT_W-1-i*IN_W -: IN_W] = acc_data_q[OUT_W-1-i*IN_W -: IN_W];
      else if (i == cnt_i)
        merge_data[OUT_W-1-i*IN_W -: IN_W] = st.in_data;
    end
    merge_channel = (cnt_q == '0) ? st.in_channel : acc_channel_q;
    merge_sop     = (cnt_q == '0) ? st.in_startofpacket : acc_sop_q;
    merge_error   = acc_error_q | st.in_error;

    empty_i = (R - 1 - cnt_i) * IN_SYMBOLS;
`ifdef DFA_IN_EMPTY_EN
    if (st.in_endofpacket) empty_i = empty_i + int'(st.in_empty);
`endif
    load_data = {merge_data, merge_channel, merge_error, merge_sop,
                 st.in_endofpacket, EMPTY_W'(empty_i)};

    cnt_d         = cnt_q;
    acc_data_d    = acc_data_q;
    acc_channel_d = acc_channel_q;
    acc_error_d   = acc_error_q;
    acc_sop_d     = acc_sop_q;
    case (beat)
      BEAT_FILL: begin
        cnt_d         = cnt_q + CNT_W'(1);
        acc_data_d    = merge_data;
        acc_channel_d = merge_channel;
        acc_error_d   = merge_error;
        acc_sop_d     = merge_sop;
      end
      BEAT_DONE: begin
        cnt_d       = '0;
        acc_data_d  = '0;
        acc_error_d = '0;
        acc_sop_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      acc_data_q    <= '0;
      acc_channel_q <= '0;
      acc_error_q   <= '0;
      acc_sop_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_data_q    <= acc_data_d;
      acc_channel_q <= acc_channel_d;
      acc_error_q   <= acc_error_d;
      acc_sop_q     <= acc_sop_d;
    end
  end

  avalon_st_dfa_out_reg #(.W(PAY_W)) u_out_reg (
    .clk       (clk),
    .rst       (reset),
    .load      (beat == BEAT_DONE),
    .load_data (load_data),
    .out_ready (st.out_ready),
    .out_valid (st.out_valid),
    .out_data  (out_payload),
    .in_ready  (in_ready)
  );

  assign st.in_ready = in_ready;
  assign {st.out_data, st.out_channel, st.out_error, st.out_startofpacket,
          st.out_endofpacket, st.out_empty} = out_payload;

endmodule

// File: tb/tb_nios_system_avalon_st_upsize_adapter.sv
// Directed bench for the upsize adapter; DFA_IN_EMPTY_EN selects the IN=2/OUT=8 build.
module tb_nios_system_avalon_st_upsize_adapter;

`ifdef DFA_IN_EMPTY_EN
  localparam int IN_S  = 2;
  localparam int OUT_S = 8;
`else
  localparam int IN_S  = 1;
  localparam int OUT_S = 4;
`endif
  localparam int IN_W = 8 * IN_S;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic [1:0]  ch;
    logic [5:0]  err;
    logic        sop;
    logic        eop;
    logic [3:0]  iemp;
    logic        ordy;
    logic        e_ird;
    logic        e_vld;
    logic [63:0] e_data;
    logic [1:0]  e_ch;
    logic [5:0]  e_err;
    logic        e_sop;
    logic        e_eop;
    logic [3:0]  e_emp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[$];

  nios_system_avalon_st_upsize_adapter_if #(
    .SYMBOL_W(8), .IN_SYMBOLS(IN_S), .OUT_SYMBOLS(OUT_S), .CHANNEL_W(2), .ERROR_W(6)
  ) ifc ();

  nios_system_avalon_st_upsize_adapter #(
    .SYMBOL_W(8), .IN_SYMBOLS(IN_S), .OUT_SYMBOLS(OUT_S), .CHANNEL_W(2), .ERROR_W(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .st    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic vld, input logic [15:0] data, input logic [1:0] ch,
                              input logic [5:0] err, input logic sop, input logic eop,
                              input logic [3:0] iemp, input logic ordy, input logic e_ird,
                              input logic e_vld, input logic [63:0] e_data, input logic [1:0] e_ch,
                              input logic [5:0] e_err, input logic e_sop, input logic e_eop,
                              input logic [3:0] e_emp);
    vec_t v;
    v.vld = vld; v.data = data; v.ch = ch; v.err = err; v.sop = sop; v.eop = eop;
    v.iemp = iemp; v.ordy = ordy; v.e_ird = e_ird; v.e_vld = e_vld; v.e_data = e_data;
    v.e_ch = e_ch; v.e_err = e_err; v.e_sop = e_sop; v.e_eop = e_eop; v.e_emp = e_emp;
    return v;
  endfunction

  // idle expectation: no beat on the output, all fields cleared
  function automatic vec_t idle_exp(input logic vld, input logic [15:0] data, input logic [1:0] ch,
                                    input logic [5:0] err, input logic sop, input logic eop,
                                    input logic ordy, input logic e_ird);
    return mk(vld, data, ch, err, sop, eop, 4'd0, ordy, e_ird, 1'b0, 64'd0, 2'd0, 6'd0, 1'b0, 1'b0, 4'd0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, " out_valid"}, 64'(ifc.out_valid), 64'(v.e_vld));
    chk({tag, " out_data"}, 64'(ifc.out_data), v.e_data);
    chk({tag, " out_channel"}, 64'(ifc.out_channel), 64'(v.e_ch));
    chk({tag, " out_error"}, 64'(ifc.out_error), 64'(v.e_err));
    chk({tag, " out_sop"}, 64'(ifc.out_startofpacket), 64'(v.e_sop));
    chk({tag, " out_eop"}, 64'(ifc.out_endofpacket), 64'(v.e_eop));
    chk({tag, " out_empty"}, 64'(ifc.out_empty), 64'(v.e_emp));
  endtask

  task automatic drive(input vec_t v);
    ifc.in_valid         = v.vld;
    ifc.in_data          = v.data[IN_W-1:0];
    ifc.in_channel       = v.ch;
    ifc.in_error         = v.err;
    ifc.in_startofpacket = v.sop;
    ifc.in_endofpacket   = v.eop;
`ifdef DFA_IN_EMPTY_EN
    ifc.in_empty         = v.iemp[0:0];
`endif
    ifc.out_ready        = v.ordy;
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " in_ready"}, 64'(ifc.in_ready), 64'(v.e_ird));
    @(posedge clk);
    #1;
    chk_out(tag, v);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk({tag, " out_valid async"}, 64'(ifc.out_valid), 64'd0);
    chk({tag, " out_data async"}, 64'(ifc.out_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(idle_exp(1'b0, 16'd0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", idle_exp(1'b0, 16'd0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("reset in_ready", 64'(ifc.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

`ifdef DFA_IN_EMPTY_EN
    vecs.push_back(idle_exp(1'b1, 16'h1122, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'h3344, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 16'h5566, 2'd0, 6'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1,
                      1'b1, 64'h1122334455660000, 2'd0, 6'd0, 1'b1, 1'b1, 4'd3));
    vecs.push_back(idle_exp(1'b1, 16'h0102, 2'd1, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'h0304, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'h0506, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 16'h0708, 2'd1, 6'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1,
                      1'b1, 64'h0102030405060708, 2'd1, 6'd0, 1'b1, 1'b1, 4'd1));
    vecs.push_back(idle_exp(1'b0, 16'h0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);
`else
    // continuous stream, then error/channel merge, then short packets back to back
    vecs.push_back(idle_exp(1'b1, 16'h11, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'h22, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'h33, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 16'h44, 2'd0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1,
                      1'b1, 64'h11223344, 2'd0, 6'd0, 1'b1, 1'b1, 4'd0));
    vecs.push_back(idle_exp(1'b1, 16'h01, 2'd2, 6'h01, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'h02, 2'd2, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'h03, 2'd2, 6'h04, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 16'h04, 2'd2, 6'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1,
                      1'b1, 64'h01020304, 2'd2, 6'h05, 1'b1, 1'b1, 4'd0));
    vecs.push_back(idle_exp(1'b1, 16'hAA, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 16'hBB, 2'd0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1,
                      1'b1, 64'hAABB0000, 2'd0, 6'd0, 1'b1, 1'b1, 4'd2));
    vecs.push_back(mk(1'b1, 16'hCC, 2'd0, 6'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1,
                      1'b1, 64'hCC000000, 2'd0, 6'd0, 1'b1, 1'b1, 4'd3));
    vecs.push_back(idle_exp(1'b0, 16'h0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b0, 16'h0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // eight-group packet: first beat full without eop, second carries eop only
    vecs.push_back(idle_exp(1'b1, 16'hA1, 2'd1, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'hA2, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'hA3, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 16'hA4, 2'd1, 6'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1,
                      1'b1, 64'hA1A2A3A4, 2'd1, 6'd0, 1'b1, 1'b0, 4'd0));
    vecs.push_back(idle_exp(1'b1, 16'hB1, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'hB2, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(idle_exp(1'b1, 16'hB3, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 16'hB4, 2'd1, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1,
                      1'b1, 64'hB1B2B3B4, 2'd1, 6'd0, 1'b0, 1'b1, 4'd0));
    vecs.push_back(idle_exp(1'b0, 16'h0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

    // backpressure: hold a completed beat for 10 cycles with a pending group
    apply("bp fill0", idle_exp(1'b1, 16'h55, 2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    apply("bp fill1", idle_exp(1'b1, 16'h66, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    apply("bp fill2", idle_exp(1'b1, 16'h77, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    apply("bp done", mk(1'b1, 16'h88, 2'd0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1,
                        1'b1, 64'h55667788, 2'd0, 6'd0, 1'b1, 1'b1, 4'd0));
    for (int k = 0; k < 10; k++)
      apply($sformatf("bp hold%0d", k), mk(1'b1, 16'h99, 2'd0, 6'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0,
                                           1'b1, 64'h55667788, 2'd0, 6'd0, 1'b1, 1'b1, 4'd0));
    apply("bp release", idle_exp(1'b1, 16'h99, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    apply("bp next1", idle_exp(1'b1, 16'hAA, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    apply("bp next2", idle_exp(1'b1, 16'hBB, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    apply("bp next3", mk(1'b1, 16'hCC, 2'd0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1,
                         1'b1, 64'h99AABBCC, 2'd0, 6'd0, 1'b1, 1'b1, 4'd0));
    apply("bp idle", idle_exp(1'b0, 16'h0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));

    // reset with a beat held, then reset with a partial beat accumulated
    apply("rst a0", idle_exp(1'b1, 16'hF1, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    apply("rst a1", mk(1'b1, 16'hF2, 2'd0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1,
                       1'b1, 64'hF1F20000, 2'd0, 6'd0, 1'b1, 1'b1, 4'd2));
    pulse_reset("rst held");
    apply("rst b0", idle_exp(1'b1, 16'hF3, 2'd3, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b1));
    apply("rst b1", idle_exp(1'b1, 16'hF4, 2'd3, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1));
    pulse_reset("rst partial");
    apply("rst c0", idle_exp(1'b1, 16'h01, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    apply("rst c1", idle_exp(1'b1, 16'h02, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    apply("rst c2", idle_exp(1'b1, 16'h03, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    apply("rst c3", mk(1'b1, 16'h04, 2'd0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1,
                       1'b1, 64'h01020304, 2'd0, 6'd0, 1'b1, 1'b1, 4'd0));
    apply("rst idle", idle_exp(1'b0, 16'h0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
